// File: rtl/jt51_wrq.sv
// Purpose : host-side register write queue in front of jt51; replays each (addr, data) write
//           as an address strobe then a data strobe on cen, then waits for busy (dout[7]) to clear.
// Latency : push at edge T -> FSM in ADDR at T+1 -> cs_n/wr_n low from T+2.
// Backpressure: wr_ready = !full (registered occupancy only); a full queue refuses a push even on a pop cycle.
// Ports   : clk/rst/cen      - clock, sync active-high reset, jt51 clock enable (cen_p1)
//           wr_valid/wr_ready/wr_addr/wr_data - host write handshake
//           full/empty/level - queue occupancy; err_timeout - sticky busy-timeout flag
//           cs_n/wr_n/a0/din - registered jt51 bus; dout - jt51 status (bit 7 = busy)
module jt51_wrq #(
    parameter int DW_LOG2     = 3,
    parameter int STROBE_CEN  = 2,
    parameter int BUSY_SETTLE = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic               rst,
    input  logic               clk,
    input  logic               cen,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [7:0]         wr_addr,
    input  logic [7:0]         wr_data,
    output logic               full,
    output logic               empty,
    output logic [DW_LOG2:0]   level,
    output logic               err_timeout,
    output logic               cs_n,
    output logic               wr_n,
    output logic               a0,
    output logic [7:0]         din,
    input  logic [7:0]         dout
);

    localparam int                 DEPTH    = 1 << DW_LOG2;
    localparam logic [DW_LOG2:0]   DEPTH_L  = (DW_LOG2+1)'(DEPTH);
    localparam logic [DW_LOG2:0]   LVL_ONE  = 1;
    localparam logic [DW_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [7:0]         STROBE_LAST  = 8'(STROBE_CEN - 1);
    localparam logic [7:0]         SETTLE_LAST  = 8'(BUSY_SETTLE - 1);
    localparam logic [7:0]         TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_GAP, S_DATA, S_SETTLE, S_POLL
    } state_t;

    // ---------------- FIFO ----------------
    logic [15:0]        mem [DEPTH];
    logic [DW_LOG2-1:0] wptr, rptr;
    logic               push, pop;
    logic [15:0]        head;

    assign full     = (level == DEPTH_L);
    assign empty    = (level == '0);
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign head     = mem[rptr];

    // Storage needs no reset: stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {wr_addr, wr_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // ---------------- bus sequencer ----------------
    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       strobe_n, strobe_nxt;
    logic       a0_nxt;
    logic [7:0] din_nxt;
    logic       err_nxt;
    logic       busy;
    logic       unused_dout;

    assign busy        = dout[7];
    assign unused_dout = ^dout[6:0];

    // One register drives both strobes so they can never skew apart.
    assign cs_n = strobe_n;
    assign wr_n = strobe_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            strobe_n    <= 1'b1;
            a0          <= 1'b0;
            din         <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            strobe_n    <= strobe_nxt;
            a0          <= a0_nxt;
            din         <= din_nxt;
            err_timeout <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        strobe_nxt = 1'b1;
        a0_nxt     = a0;
        din_nxt    = din;
        err_nxt    = err_timeout;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (!empty && !busy) begin
                    state_nxt = S_ADDR;
                    din_nxt   = head[15:8];
                    a0_nxt    = 1'b0;
                end
            end
            // din/a0 were set up on entry; the strobe drops one edge later and
            // only cen pulses seen with the strobe already low count toward its width.
            S_ADDR, S_DATA: begin
                strobe_nxt = 1'b0;
                if (!strobe_n && cen) begin
                    if (cnt == STROBE_LAST) begin
                        strobe_nxt = 1'b1;
                        cnt_nxt    = '0;
                        if (state == S_ADDR) begin
                            state_nxt = S_GAP;
                        end else begin
                            state_nxt = S_SETTLE;
                            pop       = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            S_GAP: begin
                if (cen) begin
                    state_nxt = S_DATA;
                    din_nxt   = head[7:0];
                    a0_nxt    = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cen) begin
                    if (cnt == SETTLE_LAST) begin
                        state_nxt = S_POLL;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            S_POLL: begin
                if (!busy) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cen) begin
                    if (cnt == TIMEOUT_LAST) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_jt51_wrq.sv
// Purpose : self-checking bench for jt51_wrq (cycle table for one write, directed corner sequences).
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: exercises full-queue refusal and refill after a pop.
module tb_jt51_wrq;

    logic       clk;
    logic       rst;
    logic       cen;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [3:0] level;
    logic       err_timeout;
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] din;
    logic [7:0] dout;

    int total = 0;
    int bad   = 0;

    jt51_wrq dut (
        .rst         (rst),
        .clk         (clk),
        .cen         (cen),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .err_timeout (err_timeout),
        .cs_n        (cs_n),
        .wr_n        (wr_n),
        .a0          (a0),
        .din         (din),
        .dout        (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic       cen;
        logic [7:0] addr;
        logic [7:0] data;
        logic       e_strb;
        logic       e_a0;
        logic [7:0] e_din;
        logic [3:0] e_lvl;
        logic       e_empty;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic vld, input logic c, input logic [7:0] ad, input logic [7:0] da,
                       input logic e_strb, input logic e_a0, input logic [7:0] e_din,
                       input logic [3:0] e_lvl, input logic e_empty);
        vec_t v;
        v.vld = vld; v.cen = c; v.addr = ad; v.data = da;
        v.e_strb = e_strb; v.e_a0 = e_a0; v.e_din = e_din; v.e_lvl = e_lvl; v.e_empty = e_empty;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        wr_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push1(input logic [7:0] ad, input logic [7:0] da);
        wr_valid = 1'b1;
        wr_addr  = ad;
        wr_data  = da;
        tick();
        wr_valid = 1'b0;
    endtask

    // Returns right after the edge that releases a data strobe.
    task automatic wait_data_end(input string name);
        logic prev;
        bit   seen;
        prev = cs_n;
        seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            tick();
            if (!prev && cs_n && a0) seen = 1;
            prev = cs_n;
        end
        check(name, seen, 1);
    endtask

    initial begin
        cen      = 1'b1;
        dout     = 8'h00;
        wr_addr  = 8'h00;
        wr_data  = 8'h00;
        wr_valid = 1'b0;
        rst      = 1'b0;
        do_reset();

        check("reset_outs", {cs_n, wr_n, a0, din, wr_ready, full, empty, level, err_timeout},
              {1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0});

        // ---- single write 0x14/0x35, cen every 2nd clock, busy low ----
        //   vld cen  addr   data   strb a0  din    lvl  empty
        add(1, 1, 8'h14, 8'h35, 1, 0, 8'h00, 4'd1, 0);  // push
        add(0, 0, 8'h00, 8'h00, 1, 0, 8'h14, 4'd1, 0);  // IDLE -> ADDR, address set up
        add(0, 1, 8'h00, 8'h00, 0, 0, 8'h14, 4'd1, 0);  // strobe low
        add(0, 0, 8'h00, 8'h00, 0, 0, 8'h14, 4'd1, 0);
        add(0, 1, 8'h00, 8'h00, 0, 0, 8'h14, 4'd1, 0);  // 1st cen while low
        add(0, 0, 8'h00, 8'h00, 0, 0, 8'h14, 4'd1, 0);
        add(0, 1, 8'h00, 8'h00, 1, 0, 8'h14, 4'd1, 0);  // 2nd cen -> release, GAP
        add(0, 0, 8'h00, 8'h00, 1, 0, 8'h14, 4'd1, 0);
        add(0, 1, 8'h00, 8'h00, 1, 1, 8'h35, 4'd1, 0);  // GAP cen -> DATA set up
        add(0, 0, 8'h00, 8'h00, 0, 1, 8'h35, 4'd1, 0);  // strobe low
        add(0, 1, 8'h00, 8'h00, 0, 1, 8'h35, 4'd1, 0);
        add(0, 0, 8'h00, 8'h00, 0, 1, 8'h35, 4'd1, 0);
        add(0, 1, 8'h00, 8'h00, 1, 1, 8'h35, 4'd0, 1);  // release + pop
        add(0, 0, 8'h00, 8'h00, 1, 1, 8'h35, 4'd0, 1);
        add(0, 1, 8'h00, 8'h00, 1, 1, 8'h35, 4'd0, 1);
        add(0, 0, 8'h00, 8'h00, 1, 1, 8'h35, 4'd0, 1);
        add(0, 1, 8'h00, 8'h00, 1, 1, 8'h35, 4'd0, 1);  // SETTLE -> POLL
        add(0, 0, 8'h00, 8'h00, 1, 1, 8'h35, 4'd0, 1);  // POLL -> IDLE

        foreach (vecs[i]) begin
            wr_valid = vecs[i].vld;
            cen      = vecs[i].cen;
            wr_addr  = vecs[i].addr;
            wr_data  = vecs[i].data;
            tick();
            check($sformatf("vec%0d {cs,wr,a0,din,lvl,empty}", i),
                  {cs_n, wr_n, a0, din, level, empty},
                  {vecs[i].e_strb, vecs[i].e_strb, vecs[i].e_a0, vecs[i].e_din, vecs[i].e_lvl, vecs[i].e_empty});
        end

        // ---- fill with busy high: 8 accepted, 9th refused ----
        do_reset();
        cen  = 1'b1;
        dout = 8'h80;
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 8'h10 + 8'(i);
            wr_data  = 8'h40 + 8'(i);
            check($sformatf("ready_before_push%0d", i), wr_ready, (i < 8));
            tick();
            check($sformatf("level_after_push%0d", i), level, (i < 8) ? i + 1 : 8);
        end
        wr_valid = 1'b0;
        check("full_state {full,rdy,cs}", {full, wr_ready, cs_n}, {1'b1, 1'b0, 1'b1});

        // ---- busy released with wr_valid held: no push on the pop cycle, refill next edge ----
        begin
            bit got7;
            bit seen_addr;
            got7      = 0;
            seen_addr = 0;
            wr_valid  = 1'b1;
            wr_addr   = 8'hA0;
            wr_data   = 8'hB0;
            dout      = 8'h00;
            for (int c = 0; c < 40 && !got7; c++) begin
                tick();
                if (!cs_n && !a0 && !seen_addr) begin
                    seen_addr = 1;
                    check("first_addr_din", din, 8'h10);
                end
                if (level == 4'd7) got7 = 1;
                else check("level_held_8", level, 8);
            end
            check("pop_seen", got7, 1);
            check("first_addr_strobe_seen", seen_addr, 1);
            tick();
            check("refill {level,full}", {level, full}, {4'd8, 1'b1});
            wr_valid = 1'b0;
        end

        // ---- busy high for 100 cen after a data strobe ----
        do_reset();
        cen  = 1'b1;
        dout = 8'h00;
        push1(8'h21, 8'h31);
        push1(8'h22, 8'h32);
        wait_data_end("busy100_data_end");
        dout = 8'h80;
        begin
            bit early;
            bit found;
            early = 0;
            found = 0;
            for (int k = 0; k < 100; k++) begin
                tick();
                if (!cs_n) early = 1;
            end
            check("no_strobe_while_busy", early, 0);
            check("level_while_busy", level, 1);
            dout = 8'h00;
            for (int k = 0; k < 20 && !found; k++) begin
                tick();
                if (!cs_n) found = 1;
            end
            check("next_addr_after_busy", found, 1);
            check("next_addr {a0,din,err}", {a0, din, err_timeout}, {1'b0, 8'h22, 1'b0});
        end

        // ---- busy stuck high: timeout after 255 cen in POLL, sticky until rst ----
        do_reset();
        cen  = 1'b1;
        dout = 8'h00;
        push1(8'h30, 8'h31);
        wait_data_end("timeout_data_end");
        dout = 8'h80;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 256) check("err_before_timeout", err_timeout, 0);
            if (k == 257) check("err_at_timeout", err_timeout, 1);
        end
        check("err_after_300", err_timeout, 1);
        dout = 8'h00;
        push1(8'h32, 8'h33);
        wait_data_end("post_timeout_write");
        check("err_sticky", err_timeout, 1);
        do_reset();
        check("err_cleared_by_rst", err_timeout, 0);

        // ---- reset during a data strobe ----
        cen  = 1'b1;
        dout = 8'h00;
        push1(8'h41, 8'h51);
        push1(8'h42, 8'h52);
        push1(8'h43, 8'h53);
        begin
            bit in_data;
            in_data = 0;
            for (int c = 0; c < 40 && !in_data; c++) begin
                tick();
                if (!cs_n && a0) in_data = 1;
            end
            check("reached_data_strobe", in_data, 1);
        end
        rst = 1'b1;
        tick();
        check("rst_mid {cs,wr,level,empty,rdy}", {cs_n, wr_n, level, empty, wr_ready},
              {1'b1, 1'b1, 4'd0, 1'b1, 1'b1});
        rst = 1'b0;
        begin
            bit strobed;
            strobed = 0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (!cs_n) strobed = 1;
            end
            check("no_strobe_after_rst", strobed, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jt51_wrq.md
# jt51_wrq

Host-side register write queue placed directly upstream of the jt51 top level, driving its `cs_n`/`wr_n`/`a0`/`din` bus and reading `dout`. It buffers (address, data) register writes from a CPU or sequencer with a valid/ready handshake. It replays each write as an address strobe followed by a data strobe, timed on `cen`. Before issuing the next write it waits for the chip's busy flag (`dout[7]`) to clear, with a timeout that raises a sticky error.

## Interface
- `DW_LOG2`, 3: log2 of FIFO depth (8 entries).
- `STROBE_CEN`, 2: number of `cen`-high cycles each write strobe is held low.
- `BUSY_SETTLE`, 2: `cen`-high cycles to wait after a data strobe before polling busy.
- `TIMEOUT`, 255: `cen`-high cycles of continuous busy, 8-bit, before the error flag is set.
- `rst` in 1: reset, synchronous, active-high.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `cen` in 1: clock enable; connect to the same `cen_p1` that feeds jt51.
- `wr_valid` in 1: host offers a write.
- `wr_ready` out 1: queue accepts a write; equals `!full`.
- `wr_addr` in 8: register address.
- `wr_data` in 8: register data.
- `full` out 1: FIFO holds 2^DW_LOG2 entries.
- `empty` out 1: FIFO holds 0 entries.
- `level` out DW_LOG2+1: number of stored entries.
- `err_timeout` out 1: sticky; set on busy timeout; cleared only by `rst`.
- `cs_n` out 1: jt51 chip select, active low.
- `wr_n` out 1: jt51 write, active low.
- `a0` out 1: 0 selects the address port, 1 selects the data port.
- `din` out 8: jt51 data bus.
- `dout` in 8: jt51 status; bit 7 is busy.

## Operation
- Push: occurs when `wr_valid && wr_ready` at a clock edge; `{wr_addr, wr_data}` is written at the write pointer. The push does not depend on `cen`.
- `wr_ready` is derived from the registered `full` only. When full, a push is refused even if a pop occurs in the same cycle.
- Pointers are DW_LOG2 bits and wrap modulo the depth. `level` is updated every cycle:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- FSM states: IDLE, ADDR, GAP, DATA, SETTLE, POLL.
- IDLE: if `!empty && !dout[7]`, go to ADDR. Head-entry address goes to `din`, `a0=0`.
- ADDR: `cs_n=wr_n=0`. Count `cen`-high cycles; in the cycle the count reaches STROBE_CEN, go to GAP.
- GAP: `cs_n=wr_n=1`, `a0` unchanged. After one `cen`-high cycle, go to DATA. Head-entry data goes to `din`, `a0=1`.
- DATA: `cs_n=wr_n=0`, held for STROBE_CEN `cen`-high cycles. The exit cycle pops the FIFO; go to SETTLE.
- SETTLE: strobes high. After BUSY_SETTLE `cen`-high cycles, go to POLL.
- POLL: if `!dout[7]`, go to IDLE. Otherwise count `cen`-high cycles. If the count reaches TIMEOUT:
  - set `err_timeout`;
  - go to IDLE (the next write proceeds when busy is observed low).
- The busy counter clears on entry to POLL.
- Counters advance only on `cen`. FSM transitions out of IDLE do not require `cen`.
- Outputs `cs_n`, `wr_n`, `a0`, `din` are registered directly (glitch-free).

## Timing
- Reset values:
  - `cs_n=1`, `wr_n=1`, `a0=0`, `din=0`.
  - `wr_ready=1`, `full=0`, `empty=1`, `level=0`, `err_timeout=0`.
  - FSM in IDLE, pointers and counters 0.
- `rst` asserted mid-strobe: strobes go high on the next edge and the queued contents are discarded.
- Push at edge T into an empty queue with busy low:
  - `empty=0` after T.
  - FSM enters ADDR at T+1.
  - `cs_n`/`wr_n` low from T+2.
- Strobe low width is from the first asserted cycle through the STROBE_CEN-th `cen`-high cycle inclusive. Release occurs on the following edge.
- GAP is at least one `cen`-high cycle with both strobes high.
- `level` decrements on the edge after the DATA exit cycle.
- `dout[7]` is sampled directly, without synchronisation; it is in the same clock domain.

## Test plan
- Single write 0x14/0x35, `cen` every 2nd clk, busy held low:
  - `a0=0, din=0x14` low for 2 cen pulses.
  - Gap, then `a0=1, din=0x35` low for 2 cen pulses.
  - `level` 1→0.
- Push 9 writes back-to-back, FSM blocked by busy=1:
  - first 8 accepted;
  - `full=1`, `wr_ready=0`, 9th refused, `level=8`.
- Full queue, busy released, `wr_valid` held: no push on the pop cycle; push accepted on the next edge; `level` stays 8 then 7→8.
- Busy high for 100 cen pulses after a data strobe: next ADDR strobe starts only after `dout[7]` falls; `err_timeout=0`.
- Busy stuck high for 300 cen pulses: `err_timeout=1` after 255 cen in POLL; the flag stays set until `rst`.
- `rst` during DATA strobe: `cs_n=wr_n=1` on the next edge; `level=0`, `empty=1`.
